// File: rtl/note_judge.sv
// Rhythm-game note judge: times key presses against notes and reports hit/miss/recover/done.
// Define GHOST_MISS_EN to count a key press with no note in J_READY as a miss.
module note_judge #(
    parameter int WINDOW    = 8,
    parameter int NOTES     = 64,
    parameter int CHAIN     = 4,
    parameter int MISS_HOLD = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       map,
    input  logic       chance,
    input  logic       note_in,
    input  logic       key_hit,
    output logic       miss,
    output logic       done,
    output logic       recover,
    output logic       hit,
    output logic [7:0] note_count,
    output logic [2:0] streak
);

    typedef enum logic [2:0] {J_IDLE, J_READY, J_WINDOW, J_MISS, J_DONE} state_t;

    localparam logic [7:0] WIN_LAST   = 8'(WINDOW - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(MISS_HOLD - 1);
    localparam logic [2:0] CHAIN_LAST = 3'(CHAIN - 1);
    localparam logic [7:0] NOTES_MAX  = 8'(NOTES);

    state_t     state;
    logic [7:0] win_cnt;
    logic [3:0] miss_cnt;
    logic       pending;
    logic       owed;
    logic       drop;
    logic       judge_hit;
    logic       judge_miss;
    logic       ghost;
    logic       enter_miss;
    logic       at_end;
    logic [1:0] inc;
    logic [8:0] count_sum;
    logic [7:0] count_next;

`ifdef GHOST_MISS_EN
    assign ghost = (state == J_READY) && !pending && !note_in && key_hit;
`else
    assign ghost = 1'b0;
`endif

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        drop       = note_in && pending && (state == J_WINDOW || state == J_MISS);
        judge_hit  = (state == J_READY && !pending && note_in && key_hit) ||
                     (state == J_WINDOW && key_hit);
        judge_miss = (state == J_WINDOW) && !key_hit && (win_cnt == WIN_LAST);
        // A hit with a dropped note owed still has to pass through J_MISS.
        enter_miss = judge_miss || ghost || ((state == J_WINDOW) && key_hit && (owed || drop));
        inc        = {1'b0, judge_hit} + {1'b0, judge_miss} + {1'b0, drop};
        count_sum  = {1'b0, note_count} + {7'b0, inc};
        count_next = (count_sum > {1'b0, NOTES_MAX}) ? NOTES_MAX : count_sum[7:0];
        at_end     = (count_next == NOTES_MAX);
    end

    // NOTE: reset is synchronous and shares the clear path with map=0, which also aborts everything.
    always_ff @(posedge clk) begin
        if (!resetn || !map) begin
            state      <= J_IDLE;
            win_cnt    <= '0;
            miss_cnt   <= '0;
            pending    <= 1'b0;
            owed       <= 1'b0;
            note_count <= '0;
            streak     <= '0;
            miss       <= 1'b0;
            done       <= 1'b0;
            recover    <= 1'b0;
            hit        <= 1'b0;
        end else begin
            hit        <= judge_hit;
            recover    <= 1'b0;
            note_count <= count_next;

            if (state != J_DONE) begin
                if (!chance || drop || enter_miss) begin
                    streak <= '0;
                end else if (judge_hit) begin
                    if (streak == CHAIN_LAST) begin
                        streak  <= '0;
                        recover <= 1'b1;
                    end else begin
                        streak <= streak + 3'd1;
                    end
                end
            end

            case (state)
                J_IDLE: state <= J_READY;
                J_READY: begin
                    pending <= pending && note_in;
                    if (judge_hit) begin
                        if (at_end) begin
                            state <= J_DONE;
                            done  <= 1'b1;
                        end
                    end else if (note_in || pending) begin
                        state   <= J_WINDOW;
                        win_cnt <= '0;
                    end else if (ghost) begin
                        state    <= J_MISS;
                        miss     <= 1'b1;
                        miss_cnt <= '0;
                    end
                end
                J_WINDOW: begin
                    if (note_in && !pending) pending <= 1'b1;
                    if (enter_miss) begin
                        state    <= J_MISS;
                        miss     <= 1'b1;
                        miss_cnt <= '0;
                        owed     <= 1'b0;
                    end else if (judge_hit) begin
                        state <= at_end ? J_DONE : J_READY;
                        done  <= at_end;
                    end else begin
                        win_cnt <= win_cnt + 8'd1;
                        if (drop) owed <= 1'b1;
                    end
                end
                J_MISS: begin
                    if (note_in && !pending) pending <= 1'b1;
                    if (miss_cnt == HOLD_LAST) begin
                        miss <= 1'b0;
                        if (at_end) begin
                            state <= J_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= J_READY;
                        end
                    end else begin
                        miss_cnt <= miss_cnt + 4'd1;
                    end
                end
                J_DONE: state <= J_DONE;
                default: state <= J_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_judge.sv
// Directed scoreboard bench for note_judge: default instance plus a NOTES=3 instance for the done test.
module tb_note_judge;

    typedef struct packed {
        logic       miss;
        logic       done;
        logic       recover;
        logic       hit;
        logic [7:0] count;
        logic [2:0] streak;
    } obs_t;

    logic clk = 1'b0;
    logic resetn, map, chance, note_in, key_hit;
    logic miss_a, done_a, recover_a, hit_a;
    logic [7:0] count_a;
    logic [2:0] streak_a;
    logic miss_b, done_b, recover_b, hit_b;
    logic [7:0] count_b;
    logic [2:0] streak_b;
    logic use_b = 1'b0;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

`ifdef GHOST_MISS_EN
    localparam int GHOST = 1;
`else
    localparam int GHOST = 0;
`endif

    always #5 clk = ~clk;

    note_judge dut_a (
        .clk(clk), .resetn(resetn), .map(map), .chance(chance),
        .note_in(note_in), .key_hit(key_hit),
        .miss(miss_a), .done(done_a), .recover(recover_a), .hit(hit_a),
        .note_count(count_a), .streak(streak_a)
    );

    note_judge #(.NOTES(3)) dut_b (
        .clk(clk), .resetn(resetn), .map(map), .chance(chance),
        .note_in(note_in), .key_hit(key_hit),
        .miss(miss_b), .done(done_b), .recover(recover_b), .hit(hit_b),
        .note_count(count_b), .streak(streak_b)
    );

    // One clock: drive inputs, queue the expected outputs, then compare after the edge.
    task automatic cyc(input int ni, input int kh, input int em, input int ed, input int er,
                       input int eh, input int ec, input int es, input string tag);
        obs_t  want;
        obs_t  got;
        string t;
        note_in = (ni != 0);
        key_hit = (kh != 0);
        want.miss    = (em != 0);
        want.done    = (ed != 0);
        want.recover = (er != 0);
        want.hit     = (eh != 0);
        want.count   = 8'(ec);
        want.streak  = 3'(es);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        got  = use_b ? {miss_b, done_b, recover_b, hit_b, count_b, streak_b}
                     : {miss_a, done_a, recover_a, hit_a, count_a, streak_a};
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got miss=%b done=%b recover=%b hit=%b count=%0d streak=%0d, expected miss=%b done=%b recover=%b hit=%b count=%0d streak=%0d",
                   t, got.miss, got.done, got.recover, got.hit, got.count, got.streak,
                   want.miss, want.done, want.recover, want.hit, want.count, want.streak);
        end
    endtask

    task automatic idle(input int n, input int em, input int ec, input int es, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, em, 0, 0, 0, ec, es, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; map = 1'b1; chance = 1'b0; note_in = 1'b0; key_hit = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "reset");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, "reset_ignores_inputs");
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle_to_ready");

        // Hit three cycles after the note
        cyc(1, 0, 0, 0, 0, 0, 0, 0, "hit_note");
        idle(2, 0, 0, 0, "hit_wait");
        cyc(0, 1, 0, 0, 0, 1, 1, 0, "hit_pulse");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, "hit_clear");

        // Full window with no key: miss held four cycles
        cyc(1, 0, 0, 0, 0, 0, 1, 0, "miss_note");
        idle(7, 0, 1, 0, "miss_window");
        idle(4, 1, 2, 0, "miss_hold");
        cyc(0, 0, 0, 0, 0, 0, 2, 0, "miss_end");

        // Note arriving during J_MISS opens a window; key at expiry is a hit
        cyc(1, 0, 0, 0, 0, 0, 2, 0, "pend_note");
        idle(7, 0, 2, 0, "pend_window");
        cyc(0, 0, 1, 0, 0, 0, 3, 0, "pend_miss");
        cyc(1, 0, 1, 0, 0, 0, 3, 0, "pend_note_in_miss");
        idle(2, 1, 3, 0, "pend_miss_hold");
        cyc(0, 0, 0, 0, 0, 0, 3, 0, "pend_ready");
        cyc(0, 0, 0, 0, 0, 0, 3, 0, "pend_window_open");
        idle(7, 0, 3, 0, "pend_window");
        cyc(0, 1, 0, 0, 0, 1, 4, 0, "pend_expiry_hit");
        cyc(0, 0, 0, 0, 0, 0, 4, 0, "pend_after_hit");

        // Same-cycle note and key: immediate hit, no window left behind
        cyc(1, 1, 0, 0, 0, 1, 5, 0, "imm_hit");
        idle(10, 0, 5, 0, "imm_no_window");

        // Four hits with chance high give a recover
        chance = 1'b1;
        cyc(1, 1, 0, 0, 0, 1, 6, 1, "rec_hit1");
        cyc(0, 0, 0, 0, 0, 0, 6, 1, "rec_gap1");
        cyc(1, 1, 0, 0, 0, 1, 7, 2, "rec_hit2");
        cyc(0, 0, 0, 0, 0, 0, 7, 2, "rec_gap2");
        cyc(1, 1, 0, 0, 0, 1, 8, 3, "rec_hit3");
        cyc(0, 0, 0, 0, 0, 0, 8, 3, "rec_gap3");
        cyc(1, 1, 0, 0, 1, 1, 9, 0, "rec_hit4");
        cyc(0, 0, 0, 0, 0, 0, 9, 0, "rec_clear");
        chance = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0, 0, 1, 10 + i, 0, "norec_hit");
            cyc(0, 0, 0, 0, 0, 0, 10 + i, 0, "norec_gap");
        end
        chance = 1'b1;
        cyc(1, 1, 0, 0, 0, 1, 14, 1, "chance_hit");
        chance = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 14, 0, "chance_low_clears");

        // Third note while one is pending is dropped; the hit then still goes through J_MISS
        chance = 1'b1;
        cyc(1, 1, 0, 0, 0, 1, 15, 1, "drop_pre_hit");
        cyc(0, 0, 0, 0, 0, 0, 15, 1, "drop_pre_gap");
        cyc(1, 0, 0, 0, 0, 0, 15, 1, "drop_note1");
        cyc(1, 0, 0, 0, 0, 0, 15, 1, "drop_note2_pending");
        cyc(1, 0, 0, 0, 0, 0, 16, 0, "drop_note3_dropped");
        cyc(0, 1, 1, 0, 0, 1, 17, 0, "drop_hit_then_miss");
        idle(3, 1, 17, 0, "drop_miss_hold");
        cyc(0, 0, 0, 0, 0, 0, 17, 0, "drop_ready");
        cyc(0, 0, 0, 0, 0, 0, 17, 0, "drop_pending_window");
        cyc(0, 1, 0, 0, 0, 1, 18, 1, "drop_pending_hit");
        chance = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 18, 0, "drop_chance_off");

        // Stray key press
        cyc(0, 1, GHOST, 0, 0, 0, 18, 0, "ghost_key");
        idle(3, GHOST, 18, 0, "ghost_hold");
        cyc(0, 0, 0, 0, 0, 0, 18, 0, "ghost_end");

        // Reset in the middle of a miss
        cyc(1, 0, 0, 0, 0, 0, 18, 0, "rst_note");
        idle(7, 0, 18, 0, "rst_window");
        cyc(0, 0, 1, 0, 0, 0, 19, 0, "rst_miss_entry");
        cyc(0, 0, 1, 0, 0, 0, 19, 0, "rst_miss_hold");
        resetn = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "rst_mid_miss");
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "rst_ready");

        // NOTES=3 instance: three hits finish the song
        use_b = 1'b1;
        cyc(1, 1, 0, 0, 0, 1, 1, 0, "done_hit1");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, "done_gap1");
        cyc(1, 1, 0, 0, 0, 1, 2, 0, "done_hit2");
        cyc(0, 0, 0, 0, 0, 0, 2, 0, "done_gap2");
        cyc(1, 1, 0, 1, 0, 1, 3, 0, "done_hit3");
        cyc(0, 0, 0, 1, 0, 0, 3, 0, "done_held");
        cyc(1, 1, 0, 1, 0, 0, 3, 0, "done_ignores_inputs");
        map = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "done_map_low");

        // map low mid-window aborts the judgement
        use_b = 1'b0;
        map = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "map_ready");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, "map_note");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "map_window");
        map = 1'b0;
        cyc(0, 1, 0, 0, 0, 0, 0, 0, "map_abort");
        map = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "map_restart");
        idle(10, 0, 0, 0, "map_no_leftover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
